pb_port_master: RTL and testbench
=================================

# pb_port_master

Initiator for the PicoBlaze-style 8-bit port bus (`port_id`, `out_port`, `write_strobe`, `read_strobe`, `in_port`). It turns single commands from a host-side logic block or test harness into bus cycles that drive port-mapped peripherals such as the UART register block. It supports three operations: one write, one read, and a poll, which repeats reads until a masked value matches or a timeout expires. It sits where the processor would sit, so peripherals can be exercised or driven without a CPU.

## Interface
- `PARK_ADDR`, 8'hFF: `port_id` value driven whenever no access is in progress. It must decode to no register.
- `POLL_LIMIT`, 16'd1000: maximum number of reads in one poll. 0 means unlimited.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: operation. 00 = write, 01 = read, 10 = poll, 11 = reserved (treated as read).
- `cmd_addr` in 8: target `port_id`.
- `cmd_wdata` in 8: write data.
- `cmd_mask` in 8: poll mask.
- `cmd_match` in 8: poll compare value.
- `rsp_valid` out 1: response available. Held until accepted.
- `rsp_ready` in 1: response accepted on an edge where `rsp_valid && rsp_ready`.
- `rsp_rdata` out 8: last data read. 0 for a write.
- `rsp_timeout` out 1: poll ended at `POLL_LIMIT` without a match.
- `port_id` out 8: bus address.
- `out_port` out 8: bus write data.
- `write_strobe` out 1: one-cycle write qualifier.
- `read_strobe` out 1: one-cycle read qualifier.
- `in_port` in 8: registered peripheral read data, valid one cycle after `port_id` is presented.

## Operation
- States: IDLE, WR, RD_ADDR, RD_WAIT, CHECK, RESP.
- IDLE
  - `cmd_ready`=1. All other bus outputs are at their parked values.
  - On accept, latch all `cmd_*` fields and clear the poll counter.
  - Go to WR if op is 00, otherwise RD_ADDR.
- WR: `port_id`=addr, `out_port`=wdata, `write_strobe`=1 for exactly one cycle. Then RESP with `rsp_rdata`=0.
- RD_ADDR: `port_id`=addr, `read_strobe`=1, poll counter increments. Then RD_WAIT.
- RD_WAIT
  - `port_id`=addr held, `read_strobe`=0.
  - `in_port` is captured into `rsp_rdata` at the end of this cycle.
  - Next state: RESP if op is read, CHECK if op is poll.
- CHECK: `port_id`=PARK_ADDR.
  - If `(rsp_rdata & mask) == match`, go to RESP with `rsp_timeout`=0.
  - Otherwise, if POLL_LIMIT≠0 and count==POLL_LIMIT, go to RESP with `rsp_timeout`=1.
  - Otherwise go back to RD_ADDR.
- RESP: `rsp_valid`=1 with `rsp_rdata` and `rsp_timeout` stable. Return to IDLE on `rsp_ready`. Back-pressure may last any number of cycles.
- `port_id` returns to PARK_ADDR whenever the state is not WR, RD_ADDR or RD_WAIT. Peripherals that decode reads from the address alone therefore see one access per read.
- Only one command is outstanding at a time. Every transaction passes through RESP and IDLE, so consecutive bus accesses always have at least one parked cycle between them.
- Poll counter: 16-bit, saturating. With POLL_LIMIT=0 it saturates at 16'hFFFF and never times out.
- `rsp_timeout` and `rsp_rdata` keep their values after RESP until the next response is produced.

## Timing
- All outputs are registered, except `cmd_ready` = (state==IDLE) && !reset.
- Reset values:
  - `port_id`=PARK_ADDR
  - `out_port`=0, `write_strobe`=0, `read_strobe`=0
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_timeout`=0
  - state IDLE, counter 0
- Accept edge = E0.
  - Write: strobe in cycle E0+1; `rsp_valid` from cycle E0+2.
  - Read: strobe in cycle E0+1, capture at end of E0+2; `rsp_valid` from cycle E0+3.
  - Poll: 3 cycles per iteration. A match on read n gives `rsp_valid` at cycle E0+3n+1.
- Reset mid-operation: at the reset edge the state returns to IDLE and the strobes drop. Any pending response is discarded and a partial poll is not resumed.
- `cmd_valid` is ignored outside IDLE. `rsp_ready` is ignored when `rsp_valid`=0.

## Structure
- Shared package `pb_port_pkg`:
  - op encodings `PB_OP_WRITE`, `PB_OP_READ`, `PB_OP_POLL`
  - state encoding
  - `PB_PARK_ADDR_DEFAULT`
- Single module. No sub-module is warranted; the poll counter and compare are inline.

## Test plan
- Write `addr`=8'h01, `wdata`=8'hA5. Expect `port_id`=01, `out_port`=A5 and `write_strobe` high for exactly 1 cycle at E0+1; `rsp_valid` at E0+2 with `rsp_rdata`=0.
- Read `addr`=8'h02 from a model responder that registers 8'h3C. Expect `read_strobe` 1 cycle, `rsp_rdata`=3C at E0+3, and `port_id` back to FF afterwards.
- Poll `addr`=02, `mask`=01, `match`=01, with the model returning 00, 00, 01. Expect 3 read strobes, `rsp_rdata`=01, `rsp_timeout`=0, `rsp_valid` at E0+10.
- Poll with POLL_LIMIT=4 and a model that always returns 00. Expect exactly 4 strobes, then `rsp_timeout`=1.
- Hold `rsp_ready`=0 for 5 cycles after a read. Expect `rsp_valid` and `rsp_rdata` stable, `cmd_ready`=0 and no strobes; one cycle after `rsp_ready`, `cmd_ready`=1.
- Assert `reset` during RD_WAIT of a poll. Expect outputs at reset values on the next edge, no `rsp_valid`, and a following write that completes normally.

Source files
------------

// File: rtl/pb_port_pkg.sv
// Shared encodings for the PicoBlaze-style port bus initiator.
// Holds the op codes, the FSM state codes and the default park address.
package pb_port_pkg;

  localparam int PB_DATA_W = 8;

  localparam logic [1:0] PB_OP_WRITE = 2'b00;
  localparam logic [1:0] PB_OP_READ  = 2'b01;
  localparam logic [1:0] PB_OP_POLL  = 2'b10;

  localparam logic [2:0] PB_ST_IDLE    = 3'd0;
  localparam logic [2:0] PB_ST_WR      = 3'd1;
  localparam logic [2:0] PB_ST_RD_ADDR = 3'd2;
  localparam logic [2:0] PB_ST_RD_WAIT = 3'd3;
  localparam logic [2:0] PB_ST_CHECK   = 3'd4;
  localparam logic [2:0] PB_ST_RESP    = 3'd5;

  localparam logic [7:0] PB_PARK_ADDR_DEFAULT = 8'hFF;

  // The reserved op code behaves as a plain read.
  function automatic logic [1:0] pb_norm_op(input logic [1:0] op);
    return (op == 2'b11) ? PB_OP_READ : op;
  endfunction

  function automatic logic pb_poll_hit(input logic [PB_DATA_W-1:0] data,
                                       input logic [PB_DATA_W-1:0] mask,
                                       input logic [PB_DATA_W-1:0] match);
    return (data & mask) == match;
  endfunction

endpackage

// File: rtl/pb_port_master_if.sv
// Command/response handshake plus the 8-bit port bus seen by pb_port_master.
// The master modport is the initiator side; slave is the host/peripheral side.
interface pb_port_master_if;
  import pb_port_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [PB_DATA_W-1:0] cmd_addr;
  logic [PB_DATA_W-1:0] cmd_wdata;
  logic [PB_DATA_W-1:0] cmd_mask;
  logic [PB_DATA_W-1:0] cmd_match;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [PB_DATA_W-1:0] rsp_rdata;
  logic                 rsp_timeout;

  logic [PB_DATA_W-1:0] port_id;
  logic [PB_DATA_W-1:0] out_port;
  logic                 write_strobe;
  logic                 read_strobe;
  logic [PB_DATA_W-1:0] in_port;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    input  rsp_ready, in_port,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output port_id, out_port, write_strobe, read_strobe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    output rsp_ready, in_port,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  port_id, out_port, write_strobe, read_strobe
  );

endinterface

// File: rtl/pb_port_master.sv
// Port bus initiator: turns single write/read/poll commands into PicoBlaze-style
// bus cycles. All bus and response outputs are registered from next-state values.
module pb_port_master
  import pb_port_pkg::*;
#(
  parameter logic [7:0]  PARK_ADDR  = PB_PARK_ADDR_DEFAULT,
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic              clk,
  input  logic              reset,
  pb_port_master_if.master  bus
);

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [PB_DATA_W-1:0] addr_q, addr_d;
  logic [PB_DATA_W-1:0] wdata_q, wdata_d;
  logic [PB_DATA_W-1:0] mask_q, mask_d;
  logic [PB_DATA_W-1:0] match_q, match_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [PB_DATA_W-1:0] port_id_q, port_id_d;
  logic [PB_DATA_W-1:0] out_port_q, out_port_d;
  logic                 write_strobe_q, write_strobe_d;
  logic                 read_strobe_q, read_strobe_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [PB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    match_d       = match_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      PB_ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = pb_norm_op(bus.cmd_op);
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          mask_d  = bus.cmd_mask;
          match_d = bus.cmd_match;
          cnt_d   = 16'd0;
          state_d = (pb_norm_op(bus.cmd_op) == PB_OP_WRITE) ? PB_ST_WR : PB_ST_RD_ADDR;
        end
      end
      PB_ST_WR: begin
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b0;
        state_d       = PB_ST_RESP;
      end
      PB_ST_RD_ADDR: begin
        // Saturates so an unlimited poll cannot wrap back to a small count.
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d = PB_ST_RD_WAIT;
      end
      PB_ST_RD_WAIT: begin
        rsp_rdata_d = bus.in_port;
        if (op_q == PB_OP_POLL) begin
          state_d = PB_ST_CHECK;
        end else begin
          rsp_timeout_d = 1'b0;
          state_d       = PB_ST_RESP;
        end
      end
      PB_ST_CHECK: begin
        if (pb_poll_hit(rsp_rdata_q, mask_q, match_q)) begin
          rsp_timeout_d = 1'b0;
          state_d       = PB_ST_RESP;
        end else if ((POLL_LIMIT != 16'd0) && (cnt_q == POLL_LIMIT)) begin
          rsp_timeout_d = 1'b1;
          state_d       = PB_ST_RESP;
        end else begin
          state_d = PB_ST_RD_ADDR;
        end
      end
      PB_ST_RESP: begin
        if (bus.rsp_ready) state_d = PB_ST_IDLE;
      end
      default: state_d = PB_ST_IDLE;
    endcase

    // Outputs follow the state being entered so they are valid for that whole cycle.
    port_id_d      = (state_d == PB_ST_WR || state_d == PB_ST_RD_ADDR ||
                      state_d == PB_ST_RD_WAIT) ? addr_d : PARK_ADDR;
    out_port_d     = (state_d == PB_ST_WR) ? wdata_d : '0;
    write_strobe_d = (state_d == PB_ST_WR);
    read_strobe_d  = (state_d == PB_ST_RD_ADDR);
    rsp_valid_d    = (state_d == PB_ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PB_ST_IDLE;
      cnt_q          <= 16'd0;
      port_id_q      <= PARK_ADDR;
      out_port_q     <= '0;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      port_id_q      <= port_id_d;
      out_port_q     <= out_port_d;
      write_strobe_q <= write_strobe_d;
      read_strobe_q  <= read_strobe_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  // Latched command fields are only consumed after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
    match_q <= match_d;
  end

  assign bus.cmd_ready    = (state_q == PB_ST_IDLE) && !reset;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.port_id      = port_id_q;
  assign bus.out_port     = out_port_q;
  assign bus.write_strobe = write_strobe_q;
  assign bus.read_strobe  = read_strobe_q;

endmodule

// File: tb/tb_pb_port_master.sv
// Bench for pb_port_master: register-file responder plus a command-level
// reference model, directed cases followed by randomized commands.
module tb_pb_port_master;
  import pb_port_pkg::*;

  localparam logic [15:0] LIM  = 16'd4;
  localparam logic [7:0]  PARK = 8'hFF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pb_port_master_if bus ();

  pb_port_master #(.PARK_ADDR(PARK), .POLL_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral: byte registers, read data registered on the read strobe; a
  // scripted sequence can override the first reads of a command.
  bit   [7:0] mem [256];
  bit   [7:0] model_mem [256];
  logic [7:0] script_val [16];
  int script_len  = 0;
  int script_base = 0;
  int rd_cnt      = 0;
  int ridx;

  always @(posedge clk) begin
    if (bus.read_strobe) begin
      ridx = rd_cnt - script_base;
      if (ridx >= 0 && ridx < script_len) bus.in_port <= script_val[ridx];
      else                                bus.in_port <= mem[bus.port_id];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.write_strobe) mem[bus.port_id] <= bus.out_port;
  end

  // Bus monitor
  int wr_cnt = 0;
  int rdwait_bad = 0;
  int adj_bad = 0;
  logic [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00, last_rd_addr = 8'h00;
  logic prev_rd = 1'b0, prev_any = 1'b0;
  logic [7:0] prev_pid = 8'h00;

  always @(negedge clk) begin
    if (bus.write_strobe) begin
      wr_cnt++;
      last_wr_addr = bus.port_id;
      last_wr_data = bus.out_port;
    end
    if (bus.read_strobe) last_rd_addr = bus.port_id;
    if (prev_rd && !reset && bus.port_id !== prev_pid) rdwait_bad++;
    if ((bus.read_strobe || bus.write_strobe) && prev_any) adj_bad++;
    prev_rd  = bus.read_strobe;
    prev_any = bus.read_strobe || bus.write_strobe;
    prev_pid = bus.port_id;
  end

  function automatic logic [7:0] model_read(input int i, input logic [7:0] addr);
    return (i < script_len) ? script_val[i] : model_mem[addr];
  endfunction

  // Issue one command from #1 after a rising edge and check the whole transaction.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] mask, input logic [7:0] match, input int hold);
    logic [7:0] e_rdata, v, held;
    logic       e_to;
    int e_lat, e_rd, e_wr, lat, rd0, wr0, n;
    e_to = 1'b0; e_rdata = 8'h00; e_rd = 0; e_wr = 0;
    if (op == 2'b00) begin
      model_mem[addr] = wdata;
      e_lat = 2; e_wr = 1;
    end else if (op == 2'b10) begin
      n = 0;
      for (int i = 1; i <= 64; i++) begin
        v = model_read(i - 1, addr);
        n = i;
        if ((v & mask) == match) break;
        if (LIM != 0 && i == int'(LIM)) begin e_to = 1'b1; break; end
      end
      e_rdata = v; e_lat = 3 * n + 1; e_rd = n;
    end else begin
      e_rdata = model_read(0, addr); e_lat = 3; e_rd = 1;
    end

    script_base = rd_cnt;
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_mask = mask; bus.cmd_match = match;
    #1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;
    // Junk command held valid while busy must be ignored.
    bus.cmd_op = 2'($urandom); bus.cmd_addr = 8'($urandom_range(0, 254));
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin
      bus.rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.rsp_ready = 1'b0;
    check("rsp_latency", lat, e_lat);
    check("rsp_rdata", bus.rsp_rdata, e_rdata);
    check("rsp_timeout", bus.rsp_timeout, e_to);
    check("read_strobes", rd_cnt - rd0, e_rd);
    check("write_strobes", wr_cnt - wr0, e_wr);
    if (op == 2'b00) begin
      check("wr_port_id", last_wr_addr, addr);
      check("wr_out_port", last_wr_data, wdata);
    end else begin
      check("rd_port_id", last_rd_addr, addr);
    end
    held = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_port_park", bus.port_id, PARK);
      check("hold_no_strobe", rd_cnt - rd0, e_rd);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", bus.rsp_valid, 0);
    check("cmd_ready_back", bus.cmd_ready, 1);
    check("port_parked", bus.port_id, PARK);
    check("rdata_kept", bus.rsp_rdata, e_rdata);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 8'h00;
    bus.cmd_wdata = 8'h00; bus.cmd_mask = 8'h00; bus.cmd_match = 8'h00;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_port_id", bus.port_id, PARK);
    check("rst_out_port", bus.out_port, 0);
    check("rst_wstrobe", bus.write_strobe, 0);
    check("rst_rstrobe", bus.read_strobe, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    script_len = 0;
    run_cmd(PB_OP_WRITE, 8'h01, 8'hA5, 8'h00, 8'h00, 0);

    script_val[0] = 8'h3C; script_len = 1;
    run_cmd(PB_OP_READ, 8'h02, 8'h00, 8'h00, 8'h00, 0);

    script_val[0] = 8'h00; script_val[1] = 8'h00; script_val[2] = 8'h01; script_len = 3;
    run_cmd(PB_OP_POLL, 8'h02, 8'h00, 8'h01, 8'h01, 0);

    for (int i = 0; i < 8; i++) script_val[i] = 8'h00;
    script_len = 8;
    run_cmd(PB_OP_POLL, 8'h02, 8'h00, 8'h01, 8'h01, 1);

    script_val[0] = 8'h3C; script_len = 1;
    run_cmd(PB_OP_READ, 8'h02, 8'h00, 8'h00, 8'h00, 5);

    // Reset while a poll sits in RD_WAIT
    for (int i = 0; i < 8; i++) script_val[i] = 8'h00;
    script_len = 8; script_base = rd_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_op = PB_OP_POLL; bus.cmd_addr = 8'h02;
    bus.cmd_mask = 8'h01; bus.cmd_match = 8'h01;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rd_wait_port", bus.port_id, 8'h02);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_port_id", bus.port_id, PARK);
    check("mid_rst_rstrobe", bus.read_strobe, 0);
    check("mid_rst_wstrobe", bus.write_strobe, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rdata", bus.rsp_rdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", bus.rsp_valid, 0);
      check("post_rst_ready", bus.cmd_ready, 1);
    end
    script_len = 0;
    run_cmd(PB_OP_WRITE, 8'h10, 8'h5A, 8'h00, 8'h00, 0);

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      logic [7:0] m;
      script_len = $urandom_range(0, 5);
      for (int i = 0; i < 8; i++) script_val[i] = 8'($urandom_range(0, 3));
      m = 8'($urandom_range(0, 3));
      run_cmd(2'($urandom), 8'($urandom_range(0, 254)), 8'($urandom),
              m, 8'($urandom) & m, $urandom_range(0, 4));
    end

    check("rd_wait_addr_held", rdwait_bad, 0);
    check("parked_between_access", adj_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
